// File: rtl/seg_count_bcd_display.sv
// Binary count to two 7-segment digits: iterative double-dabble (one bit per clock),
// then a single encode cycle that updates both digits and the overflow flag together.
module seg_count_bcd_display #(
   parameter int COUNT_WIDTH        = 8,
   parameter bit BLANK_LEADING_ZERO = 1'b0
) (
   input  logic                   i_Clk,
   input  logic                   i_Rst_L,
   input  logic [COUNT_WIDTH-1:0] i_Count,
   output logic [6:0]             o_Segment1,
   output logic [6:0]             o_Segment2,
   output logic                   o_Busy,
   output logic                   o_Overflow
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] SHIFT  = 2'd1;
   localparam logic [1:0] ENCODE = 2'd2;

   localparam logic [3:0] LAST_ITER = 4'(COUNT_WIDTH - 1);
   localparam logic [6:0] SEG_ZERO  = 7'b1111110;

   logic [1:0]             state;
   logic                   valid;
   logic [COUNT_WIDTH-1:0] bin;
   logic [COUNT_WIDTH-1:0] last;
   logic [11:0]            bcd;
   logic [11:0]            adj;
   logic [3:0]             iter;

   function automatic logic [6:0] enc(input logic [3:0] d);
      case (d)
         4'd0:    enc = 7'b1111110;
         4'd1:    enc = 7'b0110000;
         4'd2:    enc = 7'b1101101;
         4'd3:    enc = 7'b1111001;
         4'd4:    enc = 7'b0110011;
         4'd5:    enc = 7'b1011011;
         4'd6:    enc = 7'b1011111;
         4'd7:    enc = 7'b1110000;
         4'd8:    enc = 7'b1111111;
         4'd9:    enc = 7'b1111011;
         default: enc = 7'b0000001;
      endcase
   endfunction

   // Add-3 correction applied to every nibble before the shift of the same iteration.
   always_comb begin
      adj = bcd;
      for (int i = 0; i < 3; i++) begin
         if (bcd[i*4 +: 4] >= 4'd5) adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
      end
   end

   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         state      <= IDLE;
         valid      <= 1'b0;
         bin        <= '0;
         last       <= '0;
         bcd        <= '0;
         iter       <= '0;
         o_Segment1 <= SEG_ZERO;
         o_Segment2 <= SEG_ZERO;
         o_Busy     <= 1'b0;
         o_Overflow <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (!valid || (i_Count != last)) begin
                  bin    <= i_Count;
                  last   <= i_Count;
                  bcd    <= '0;
                  iter   <= '0;
                  o_Busy <= 1'b1;
                  state  <= SHIFT;
               end
            end
            SHIFT: begin
               bcd  <= {adj[10:0], bin[COUNT_WIDTH-1]};
               bin  <= {bin[COUNT_WIDTH-2:0], 1'b0};
               iter <= iter + 4'd1;
               if (iter == LAST_ITER) state <= ENCODE;
            end
            ENCODE: begin
               o_Segment2 <= enc(bcd[3:0]);
               if (BLANK_LEADING_ZERO && (bcd[7:4] == 4'd0)) o_Segment1 <= 7'b0000000;
               else                                          o_Segment1 <= enc(bcd[7:4]);
               o_Overflow <= (bcd[11:8] != 4'd0);
               valid      <= 1'b1;
               o_Busy     <= 1'b0;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
